// File: rtl/ps2_pkg.sv
// Shared scancode constants, key indices and receiver state encoding for the
// PS/2 key decoder.
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_F     = 8'h2B;

   localparam int NUM_KEYS = 6;

   typedef enum logic [2:0] {
      KEY_UP    = 3'd0,
      KEY_DOWN  = 3'd1,
      KEY_LEFT  = 3'd2,
      KEY_RIGHT = 3'd3,
      KEY_ENTER = 3'd4,
      KEY_F     = 3'd5
   } key_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_RECV  = 2'd1,
      RX_CHECK = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic hit;
      key_e key;
   } key_hit_t;

   // Keypad codes share values with the extended arrows, so the E0 prefix decides.
   function automatic key_hit_t map_scancode(input logic [7:0] code, input logic ext);
      key_hit_t r;
      r.hit = 1'b0;
      r.key = KEY_UP;
      if (ext) begin
         case (code)
            SC_UP:    begin r.hit = 1'b1; r.key = KEY_UP;    end
            SC_DOWN:  begin r.hit = 1'b1; r.key = KEY_DOWN;  end
            SC_LEFT:  begin r.hit = 1'b1; r.key = KEY_LEFT;  end
            SC_RIGHT: begin r.hit = 1'b1; r.key = KEY_RIGHT; end
            SC_ENTER: begin r.hit = 1'b1; r.key = KEY_ENTER; end
            default:  r.hit = 1'b0;
         endcase
      end else begin
         case (code)
            SC_ENTER: begin r.hit = 1'b1; r.key = KEY_ENTER; end
            SC_F:     begin r.hit = 1'b1; r.key = KEY_F;     end
            default:  r.hit = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key/receiver outputs of the key decoder.
interface ps2_key_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       upPressed;
   logic       downPressed;
   logic       leftPressed;
   logic       rightPressed;
   logic       enterPressed;
   logic       fPressed;
   logic       rxValid;
   logic [7:0] rxByte;
   logic       frameError;

   modport master (
      output ps2_clk, ps2_data,
      input  upPressed, downPressed, leftPressed, rightPressed, enterPressed, fPressed,
      input  rxValid, rxByte, frameError
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output upPressed, downPressed, leftPressed, rightPressed, enterPressed, fPressed,
      output rxValid, rxByte, frameError
   );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, frame FSM and
// mid-frame timeout. valid_o/err_o pulse in the cycle the FSM sits in CHECK.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       err_o
);

   localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

   logic [1:0]       clk_sync_q;
   logic [1:0]       data_sync_q;
   logic             filt_q, filt_d;
   logic [7:0]       filt_cnt_q, filt_cnt_d;
   logic             fall_q, fall_d;
   rx_state_e        state_q;
   logic [3:0]       bitcnt_q;
   logic [8:0]       shift_q;
   logic [TMO_W-1:0] tmo_q;
   logic [7:0]       byte_q;
   logic             valid_q;
   logic             err_q;
   logic             frame_ok_s;

   // Filter: the counter only runs while the synchronized level disagrees with the filtered one.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = 8'd0;
      fall_d     = 1'b0;
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = clk_sync_q[1];
            fall_d = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
         end
      end else begin
         filt_cnt_d = 8'd0;
      end
   end

   // shift_q holds {parity, d7..d0} when the stop bit arrives.
   assign frame_ok_s = data_sync_q[1] & (^shift_q);

   // Synchronizers, filter registers and the receive FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         filt_cnt_q  <= 8'd0;
         fall_q      <= 1'b0;
         state_q     <= RX_IDLE;
         bitcnt_q    <= 4'd0;
         shift_q     <= 9'd0;
         tmo_q       <= '0;
         byte_q      <= 8'h00;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         fall_q      <= fall_d;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               tmo_q    <= '0;
               bitcnt_q <= 4'd0;
               if (fall_q) begin
                  if (!data_sync_q[1]) begin
                     state_q <= RX_RECV;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            RX_RECV: begin
               if (fall_q) begin
                  shift_q  <= {data_sync_q[1], shift_q[8:1]};
                  tmo_q    <= '0;
                  bitcnt_q <= bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd9) begin
                     state_q <= RX_CHECK;
                     valid_q <= frame_ok_s;
                     err_q   <= ~frame_ok_s;
                     if (frame_ok_s) begin
                        byte_q <= shift_q[7:0];
                     end
                  end
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= RX_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_ONE;
               end
            end
            RX_CHECK: state_q <= RX_IDLE;
            default:  state_q <= RX_IDLE;
         endcase
      end
   end

   assign byte_o  = byte_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 key decoder: turns accepted scancodes into one-cycle,
// repeat-suppressed key pulses for the minesweeper controller.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic              clk,
   input logic              reset,
   ps2_key_decoder_if.slave bus
);

   logic [7:0]          rx_byte_s;
   logic                rx_valid_s;
   logic                rx_err_s;
   key_hit_t            hit_s;
   logic                ext_q, ext_d;
   logic                brk_q, brk_d;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] keys_q, keys_d;
   logic                rx_valid_q;
   logic [7:0]          rx_byte_q;
   logic                frame_err_q;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk_i  (bus.ps2_clk),
      .ps2_data_i (bus.ps2_data),
      .byte_o     (rx_byte_s),
      .valid_o    (rx_valid_s),
      .err_o      (rx_err_s)
   );

   assign hit_s = map_scancode(rx_byte_s, ext_q);

   // Prefix tracking and held bitmap; a held key pulses only on its first make.
   always_comb begin
      ext_d  = ext_q;
      brk_d  = brk_q;
      held_d = held_q;
      keys_d = '0;
      if (rx_err_s) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (rx_valid_s) begin
         if (rx_byte_s == SC_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte_s == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (hit_s.hit) begin
               if (brk_q) begin
                  held_d[hit_s.key] = 1'b0;
               end else if (!held_q[hit_s.key]) begin
                  held_d[hit_s.key] = 1'b1;
                  keys_d[hit_s.key] = 1'b1;
               end else begin
                  keys_d = '0;
               end
            end else begin
               held_d = held_q;
            end
         end
      end else begin
         keys_d = '0;
      end
   end

   // Registered decoder state and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         held_q      <= '0;
         keys_q      <= '0;
         rx_valid_q  <= 1'b0;
         rx_byte_q   <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         held_q      <= held_d;
         keys_q      <= keys_d;
         rx_valid_q  <= rx_valid_s;
         frame_err_q <= rx_err_s;
         if (rx_valid_s) begin
            rx_byte_q <= rx_byte_s;
         end
      end
   end

   assign bus.upPressed    = keys_q[KEY_UP];
   assign bus.downPressed  = keys_q[KEY_DOWN];
   assign bus.leftPressed  = keys_q[KEY_LEFT];
   assign bus.rightPressed = keys_q[KEY_RIGHT];
   assign bus.enterPressed = keys_q[KEY_ENTER];
   assign bus.fPressed     = keys_q[KEY_F];
   assign bus.rxValid      = rx_valid_q;
   assign bus.rxByte       = rx_byte_q;
   assign bus.frameError   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frame-level keyboard model plus
// per-cycle comparison of every output against an expected-event queue.
module tb_ps2_key_decoder;

   localparam int FL  = 2;
   localparam int TO  = 200;
   // raw fall -> 2 sync edges, FL filter edges, strobe->CHECK, CHECK->output
   localparam int LAT = 2 + FL + 2;

   typedef struct {
      int         cyc;
      bit         valid;
      bit         err;
      logic [7:0] b;
      logic [5:0] keys;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   ps2_key_decoder_if bus();

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   ev_t        evq[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   bit [5:0]   m_held = 6'd0;
   int         err_dc = 0;
   int         err_seen = 0;
   int         pulses[6] = '{0, 0, 0, 0, 0, 0};
   int         n_valid = 0;
   int         snap[6];
   int         snap_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // key index: 0 up, 1 down, 2 left, 3 right, 4 enter, 5 f
   function automatic int key_of(input logic [7:0] b, input bit ext);
      if (ext) begin
         if (b == 8'h75) return 0;
         if (b == 8'h72) return 1;
         if (b == 8'h6B) return 2;
         if (b == 8'h74) return 3;
         if (b == 8'h5A) return 4;
         return -1;
      end
      if (b == 8'h5A) return 4;
      if (b == 8'h2B) return 5;
      return -1;
   endfunction

   task automatic model_frame(input logic [7:0] b, input bit good, input int when);
      ev_t e;
      int  k;
      e.cyc = when; e.valid = good; e.err = !good; e.b = b; e.keys = 6'd0;
      if (!good) begin
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         k = key_of(b, m_ext);
         if (k >= 0) begin
            if (m_brk) m_held[k] = 1'b0;
            else if (!m_held[k]) begin
               m_held[k] = 1'b1;
               e.keys[k] = 1'b1;
            end
         end
         m_ext = 1'b0; m_brk = 1'b0;
      end
      evq.push_back(e);
   endtask

   // Compare every cycle, #1 after the active edge.
   always @(posedge clk) begin
      ev_t        e;
      logic [5:0] act;
      cyc = cyc + 1;
      #1;
      e.cyc = cyc; e.valid = 1'b0; e.err = 1'b0; e.b = 8'h00; e.keys = 6'd0;
      if (evq.size() > 0 && evq[0].cyc == cyc) e = evq.pop_front();
      if (e.valid) m_byte = e.b;
      act = {bus.fPressed, bus.enterPressed, bus.rightPressed,
             bus.leftPressed, bus.downPressed, bus.upPressed};
      check("rxValid", 32'(bus.rxValid), 32'(e.valid));
      check("rxByte", 32'(bus.rxByte), 32'(m_byte));
      check("keys", 32'(act), 32'(e.keys));
      check("one_key_max", 32'($countones(act) <= 1), 32'd1);
      if (err_dc != 0) begin
         if (bus.frameError === 1'b1) err_seen++;
         check("key_during_err", 32'(act != 6'd0 && bus.frameError === 1'b1), 32'd0);
      end else begin
         check("frameError", 32'(bus.frameError), 32'(e.err));
      end
      for (int k = 0; k < 6; k++) if (act[k] === 1'b1) pulses[k]++;
      if (bus.rxValid === 1'b1) n_valid++;
   end

   // One PS/2 frame at a 40-clk bit period; nbits<11 truncates it, rst_bit>=0 resets mid-frame.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int rst_bit);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.ps2_data = bits[i];
         if (i == rst_bit) begin
            reset = 1'b1;
            evq.delete();
            m_ext = 1'b0; m_brk = 1'b0; m_held = 6'd0; m_byte = 8'h00;
            repeat (3) @(negedge clk);
            reset = 1'b0;
         end
         repeat (10) @(negedge clk);
         bus.ps2_clk = 1'b0;
         if (i == 10 && rst_bit < 0) model_frame(b, !bad_par, cyc + LAT);
         repeat (20) @(negedge clk);
         bus.ps2_clk = 1'b1;
         repeat (9) @(negedge clk);
      end
      bus.ps2_data = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   task automatic take_snap();
      for (int k = 0; k < 6; k++) snap[k] = pulses[k];
      snap_valid = n_valid;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      reset        = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // 1: extended up make
      take_snap();
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      check("t1_up_pulses", 32'(pulses[0] - snap[0]), 32'd1);
      check("t1_rxvalid", 32'(n_valid - snap_valid), 32'd2);
      check("t1_other_keys", 32'(pulses[1] + pulses[2] + pulses[3] + pulses[4] + pulses[5]), 32'd0);

      // 2: typematic F, break, make again
      take_snap();
      send_frame(8'h2B, 1'b0, 11, -1);
      send_frame(8'h2B, 1'b0, 11, -1);
      send_frame(8'h2B, 1'b0, 11, -1);
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'h2B, 1'b0, 11, -1);
      send_frame(8'h2B, 1'b0, 11, -1);
      check("t2_f_pulses", 32'(pulses[5] - snap[5]), 32'd2);

      // 3: parity error then good enter
      take_snap();
      send_frame(8'h5A, 1'b1, 11, -1);
      check("t3_enter_after_bad", 32'(pulses[4] - snap[4]), 32'd0);
      check("t3_no_valid_bad", 32'(n_valid - snap_valid), 32'd0);
      send_frame(8'h5A, 1'b0, 11, -1);
      check("t3_enter_pulses", 32'(pulses[4] - snap[4]), 32'd1);

      // 4: release up, make, keypad break, repeat, real break, make
      take_snap();
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      check("t4_up_still_held", 32'(pulses[0] - snap[0]), 32'd1);
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h75, 1'b0, 11, -1);
      check("t4_up_pulses", 32'(pulses[0] - snap[0]), 32'd2);

      // 5: abandoned frame times out, then extended left
      take_snap();
      err_dc = 1; err_seen = 0;
      send_frame(8'h55, 1'b0, 6, -1);
      m_ext = 1'b0; m_brk = 1'b0;
      repeat (250) @(negedge clk);
      err_dc = 0;
      check("t5_timeout_errs", 32'(err_seen), 32'd1);
      check("t5_no_valid", 32'(n_valid - snap_valid), 32'd0);
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h6B, 1'b0, 11, -1);
      check("t5_left_pulses", 32'(pulses[2] - snap[2]), 32'd1);

      // 6: reset in the middle of E0 74, then a clean E0 74
      take_snap();
      send_frame(8'hE0, 1'b0, 11, -1);
      err_dc = 1;
      send_frame(8'h74, 1'b0, 11, 4);
      repeat (300) @(negedge clk);
      err_dc = 0;
      check("t6_no_right_after_reset", 32'(pulses[3] - snap[3]), 32'd0);
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'h74, 1'b0, 11, -1);
      check("t6_right_pulses", 32'(pulses[3] - snap[3]), 32'd1);

      repeat (20) @(negedge clk);
      check("events_drained", 32'(evq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream input stage for the minesweeper controller FSM. It receives PS/2 keyboard frames and decodes the Set-2 scancodes for the arrow keys, Enter and F. It drives the controller's upPressed/downPressed/leftPressed/rightPressed/enterPressed/fPressed inputs as one-cycle, repeat-suppressed pulses.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized ps2_clk samples required before the filtered clock changes level (range 2..255)
TIMEOUT_CYCLES, 50000, clk cycles with no filtered falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk
ps2_data  input  1  raw PS/2 data, asynchronous to clk
upPressed  output  1  one-cycle pulse on make of E0 75
downPressed  output  1  one-cycle pulse on make of E0 72
leftPressed  output  1  one-cycle pulse on make of E0 6B
rightPressed  output  1  one-cycle pulse on make of E0 74
enterPressed  output  1  one-cycle pulse on make of 5A or E0 5A
fPressed  output  1  one-cycle pulse on make of 2B (non-extended only)
rxValid  output  1  one-cycle pulse when a frame is accepted
rxByte  output  8  last accepted byte; holds until the next accepted frame
frameError  output  1  one-cycle pulse on a start, parity, stop or timeout error

Behaviour:
- Reset: all outputs 0, rxByte 8'h00, filtered clock 1, synchronizers 1, receiver IDLE, ext/brk prefix flags 0, held bitmap 0. Reset applies mid-frame and clears everything at the first clk edge with reset high.
- Input conditioning: each raw input passes through a 2-FF synchronizer. Filtered clock takes the synchronized level only after FILTER_LEN consecutive equal samples. A falling edge is a 1-to-0 change of the filtered clock, registered as a single-cycle strobe. ps2_data (synchronized) is sampled on that strobe.
- Receiver FSM: IDLE, RECV, CHECK.
  - IDLE: on a strobe with data=0 (start bit), go to RECV with bitcnt=0. A strobe with data=1 gives a frameError pulse and stays IDLE.
  - RECV: each strobe shifts one bit. Bits 0..7 are data, LSB first; bit 8 is parity; bit 9 is stop. After the stop bit, go to CHECK.
  - CHECK (1 cycle): accept the frame if XOR of data and parity = 1 (odd parity) and stop = 1. Otherwise pulse frameError. Return to IDLE either way.
  - Timeout: in RECV, a counter resets on each strobe. If it reaches TIMEOUT_CYCLES-1 without a strobe, pulse frameError, go to IDLE, and clear ext/brk.
- Accept: rxByte is loaded and rxValid pulses in the cycle after CHECK. Any key pulse is coincident with rxValid. Latency from the stop-bit strobe cycle to the pulse is exactly 2 clk cycles.
- Decoder, per accepted byte:
  - E0 sets ext. F0 sets brk. Prefixes accumulate in either order.
  - Any other byte is decoded using the current ext/brk, then both flags clear.
  - Mapped key with brk=0 and held bit 0: pulse that key's output and set its held bit.
  - Mapped key with brk=0 and held bit 1 (typematic repeat): no pulse.
  - Mapped key with brk=1: clear its held bit; no pulse. Break of a key not held has no effect.
  - Unmapped codes: no pulse; held bitmap unchanged. This covers non-extended 75/72/6B/74 (keypad) and E0 2B.
- A frame error clears ext/brk but not the held bitmap.
- At most one key output is high in any cycle. Key outputs are never high while frameError is high.

Decomposition:
- Shared package ps2_pkg holds the scancode constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP=8'h75, SC_DOWN=8'h72, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_ENTER=8'h5A, SC_F=8'h2B. It also holds the key index enum (UP, DOWN, LEFT, RIGHT, ENTER, F) used for the held bitmap.
- One sub-module, ps2_rx: synchronizers, filter, receiver FSM and timeout. It outputs a byte, a valid pulse and an error pulse.
- Decoder and held bitmap stay in ps2_key_decoder.

Test Plan:
(Bench uses FILTER_LEN=2, TIMEOUT_CYCLES=200 and a 40-clk PS/2 bit period.)
1. Frames E0, 75 -> rxValid twice; upPressed high for exactly 1 cycle, 2 clks after the second stop-bit strobe; no other key output high.
2. Frames 2B, 2B, 2B (typematic), then F0 2B, then 2B -> fPressed pulses twice total: on the first 2B and on the last 2B.
3. Frame 5A with parity bit 0 (even parity) -> frameError one pulse; no rxValid; no enterPressed. Next valid 5A -> enterPressed pulse.
4. Frames E0 75 then F0 75 -> first is up make; second is keypad break; no pulse; up stays held. Then E0 F0 75, then E0 75 -> upPressed pulses again.
5. Stop after 5 data bits of a frame for 250 clks -> frameError pulse at timeout; next full frame 6B preceded by E0 -> leftPressed pulse.
6. Assert reset midway through frame E0 74 -> all outputs 0 from the reset edge; the remainder of the frame is rejected or ignored; no rightPressed; a subsequent clean E0 74 -> rightPressed pulse.
